pwm_ramp_sequencer: RTL and testbench



---
 rtl/pwm_ramp_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer
// Wishbone master that soft-starts/soft-stops PWM channels. It ramps each
// timer channel's duty register from its current value toward a requested
// target, one step per ramp tick, serving channels round-robin over a single
// write-only bus port.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   i_req_*, o_req_ready   ramp request (channel, target duty, step; step 0 = jump)
//   o_wb_*, i_wb_*         Wishbone master to the timer's duty registers
//                          (adr = {11'b0, ch, 2'b10})
//   o_active/o_done/o_err  per-channel ramp busy, completion pulse, sticky error
//
// Build option: define RAMP_READBACK_EN to verify every write with a read.
// Without it o_wb_we is tied high and i_wb_data is ignored.
//
// state | meaning
// IDLE  | waiting for a pending channel
// SCAN  | pick next pending channel round-robin, compute its next duty
// WRITE | bus write in flight, waiting for ack or timeout
// READ  | (RAMP_READBACK_EN) readback of the written duty
module pwm_ramp_sequencer #(
  parameter int          NUM_CHANNELS = 4,
  parameter int          TICK_DIV     = 1000,
  parameter int          ACK_TIMEOUT  = 16,
  parameter logic [15:0] DC_RESET     = 16'h01F4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_valid,
  input  logic [2:0]              i_req_ch,
  input  logic [15:0]             i_req_target,
  input  logic [15:0]             i_req_step,
  output logic                    o_req_ready,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [15:0]             o_wb_adr,
  output logic [15:0]             o_wb_data,
  input  logic                    i_wb_ack,
  input  logic [15:0]             i_wb_data,
  output logic [NUM_CHANNELS-1:0] o_active,
  output logic [NUM_CHANNELS-1:0] o_done,
  output logic [NUM_CHANNELS-1:0] o_err
);

  localparam int TCW = $clog2(TICK_DIV);
  localparam int TOW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
`ifdef RAMP_READBACK_EN
    S_READ,
`endif
    S_WRITE
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             cur_q  [NUM_CHANNELS];
  logic [15:0]             cur_d  [NUM_CHANNELS];
  logic [15:0]             tgt_q  [NUM_CHANNELS];
  logic [15:0]             tgt_d  [NUM_CHANNELS];
  logic [15:0]             step_q [NUM_CHANNELS];
  logic [15:0]             step_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] active_q, active_d, pending_q, pending_d;
  logic [NUM_CHANNELS-1:0] err_q, err_d, done_q, done_d;
  logic [2:0]              ptr_q, ptr_d, sel_q, sel_d;
  logic [15:0]             next_q, next_d, adr_q, adr_d, dat_q, dat_d;
  logic [TCW-1:0]          tick_q, tick_d;
  logic [TOW-1:0]          to_q, to_d;
  logic                    cyc_q, cyc_d;

  logic                    busy_bus, found;
  logic [2:0]              pick;
  logic [15:0]             p_cur, p_tgt, p_step, s_tgt, nxt, diff;
  logic [16:0]             sum17;

`ifdef RAMP_READBACK_EN
  logic                    we_q, we_d;
  assign busy_bus = (state_q == S_WRITE) || (state_q == S_READ);
  assign o_wb_we  = we_q;
`else
  logic                    unused_rd_data;
  assign unused_rd_data = ^i_wb_data;
  assign busy_bus = (state_q == S_WRITE);
  assign o_wb_we  = 1'b1;
`endif

  // Only the channel whose write is in flight is blocked; its cur is in motion.
  assign o_req_ready = !(busy_bus && (sel_q == i_req_ch));
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = cyc_q;
  assign o_wb_adr    = adr_q;
  assign o_wb_data   = dat_q;
  assign o_active    = active_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    active_d  = active_q;
    pending_d = pending_q;
    err_d     = err_q;
    done_d    = '0;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    next_d    = next_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    tick_d    = tick_q;
    to_d      = to_q;
    cyc_d     = cyc_q;
`ifdef RAMP_READBACK_EN
    we_d      = we_q;
`endif
    found     = 1'b0;
    pick      = ptr_q;
    p_cur     = '0;
    p_tgt     = '0;
    p_step    = '0;
    s_tgt     = '0;
    nxt       = '0;

    // Requests first, so a same-cycle tick sees the new active value.
    if (i_req_valid && o_req_ready) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (3'(c) == i_req_ch) begin
          tgt_d[c]  = i_req_target;
          step_d[c] = i_req_step;
          err_d[c]  = 1'b0;
          if (i_req_target == cur_q[c]) begin
            active_d[c]  = 1'b0;
            pending_d[c] = 1'b0;
            done_d[c]    = 1'b1;
          end else begin
            active_d[c] = 1'b1;
          end
        end
      end
    end

    // Round-robin: channels above the pointer first, then wrap to 0..ptr.
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!found && pending_q[c] && (c > int'(ptr_q))) begin
        found = 1'b1;
        pick  = 3'(c);
      end
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!found && pending_q[c] && (c <= int'(ptr_q))) begin
        found = 1'b1;
        pick  = 3'(c);
      end
    end

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (3'(c) == pick) begin
        p_cur  = cur_q[c];
        p_tgt  = tgt_q[c];
        p_step = step_q[c];
      end
      if (3'(c) == sel_q) s_tgt = tgt_d[c];
    end

    sum17 = {1'b0, p_cur} + {1'b0, p_step};
    diff  = p_cur - p_tgt;
    if (p_step == 16'd0)      nxt = p_tgt;
    else if (p_cur < p_tgt)   nxt = (sum17 >= {1'b0, p_tgt}) ? p_tgt : sum17[15:0];
    else if (p_cur > p_tgt)   nxt = (diff <= p_step) ? p_tgt : (p_cur - p_step);
    else                      nxt = p_tgt;

    case (state_q)
      S_IDLE: begin
        if (|pending_q) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (found) begin
          ptr_d   = pick;
          sel_d   = pick;
          next_d  = nxt;
          adr_d   = {11'b0, pick, 2'b10};
          dat_d   = nxt;
          cyc_d   = 1'b1;
          to_d    = TOW'(ACK_TIMEOUT - 1);
`ifdef RAMP_READBACK_EN
          we_d    = 1'b1;
`endif
          state_d = S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (i_wb_ack) begin
`ifdef RAMP_READBACK_EN
          we_d    = 1'b0;
          to_d    = TOW'(ACK_TIMEOUT - 1);
          state_d = S_READ;
`else
          cyc_d   = 1'b0;
          state_d = S_IDLE;
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (3'(c) == sel_q) begin
              cur_d[c]     = next_q;
              pending_d[c] = 1'b0;
              if (next_q == s_tgt) begin
                active_d[c] = 1'b0;
                done_d[c]   = 1'b1;
              end
            end
          end
`endif
        end else if (to_q == '0) begin
          cyc_d   = 1'b0;
          state_d = S_IDLE;
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (3'(c) == sel_q) begin
              err_d[c]     = 1'b1;
              active_d[c]  = 1'b0;
              pending_d[c] = 1'b0;
            end
          end
        end else begin
          to_d = to_q - 1'b1;
        end
      end
`ifdef RAMP_READBACK_EN
      S_READ: begin
        if (i_wb_ack || (to_q == '0)) begin
          cyc_d   = 1'b0;
          state_d = S_IDLE;
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (3'(c) == sel_q) begin
              pending_d[c] = 1'b0;
              if (i_wb_ack && (i_wb_data == next_q)) begin
                cur_d[c] = next_q;
                if (next_q == s_tgt) begin
                  active_d[c] = 1'b0;
                  done_d[c]   = 1'b1;
                end
              end else begin
                err_d[c]    = 1'b1;
                active_d[c] = 1'b0;
              end
            end
          end
        end else begin
          to_d = to_q - 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Tick re-arms every active channel; unserved pendings are absorbed, not queued.
    if (tick_q == TCW'(TICK_DIV - 1)) begin
      tick_d    = '0;
      pending_d = active_d;
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        cur_q[c]  <= DC_RESET;
        tgt_q[c]  <= DC_RESET;
        step_q[c] <= '0;
      end
      active_q  <= '0;
      pending_q <= '0;
      err_q     <= '0;
      done_q    <= '0;
      ptr_q     <= 3'(NUM_CHANNELS - 1);
      sel_q     <= '0;
      next_q    <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      tick_q    <= '0;
      to_q      <= '0;
      cyc_q     <= 1'b0;
`ifdef RAMP_READBACK_EN
      we_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      done_q    <= done_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      next_q    <= next_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      tick_q    <= tick_d;
      to_q      <= to_d;
      cyc_q     <= cyc_d;
`ifdef RAMP_READBACK_EN
      we_q      <= we_d;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer (default build) with TICK_DIV=4 and a
// timer model that acks one cycle after strobe unless ack_en is low.
module tb_pwm_ramp_sequencer;
  localparam int NCH  = 4;
  localparam int TDIV = 4;
  localparam int ATO  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_req_valid = 1'b0;
  logic [2:0]      i_req_ch = '0;
  logic [15:0]     i_req_target = '0;
  logic [15:0]     i_req_step = '0;
  logic            o_req_ready;
  logic            o_wb_cyc, o_wb_stb, o_wb_we;
  logic [15:0]     o_wb_adr, o_wb_data;
  logic            i_wb_ack;
  logic [15:0]     i_wb_data = '0;
  logic [NCH-1:0]  o_active, o_done, o_err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pwm_ramp_sequencer #(
    .NUM_CHANNELS(NCH), .TICK_DIV(TDIV), .ACK_TIMEOUT(ATO), .DC_RESET(16'h01F4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ch(i_req_ch),
    .i_req_target(i_req_target), .i_req_step(i_req_step),
    .o_req_ready(o_req_ready),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
    .o_active(o_active), .o_done(o_done), .o_err(o_err)
  );

  // Timer model: registered ack, one cycle after strobe.
  logic ack_en = 1'b1;
  logic ack_q;
  always @(posedge clk or posedge rst) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= o_wb_cyc & o_wb_stb & ~ack_q & ack_en;
  end
  assign i_wb_ack = ack_q;

  logic [15:0] wr_adr[$];
  logic [15:0] wr_dat[$];
  int          done_cnt[NCH];
  int          cyc_cycles = 0;

  initial for (int c = 0; c < NCH; c++) done_cnt[c] = 0;

  always @(negedge clk) begin
    if (o_wb_cyc && o_wb_stb && o_wb_we && i_wb_ack) begin
      wr_adr.push_back(o_wb_adr);
      wr_dat.push_back(o_wb_data);
    end
    if (o_wb_cyc) cyc_cycles++;
    for (int c = 0; c < NCH; c++) if (o_done[c]) done_cnt[c]++;
  end

  // Drives a request at posedge+1 phase and returns at posedge+1 after acceptance.
  task automatic do_req(input logic [2:0] ch, input logic [15:0] tgt, input logic [15:0] stp);
    int k;
    k = 0;
    i_req_valid = 1'b1; i_req_ch = ch; i_req_target = tgt; i_req_step = stp;
    @(negedge clk);
    while (!o_req_ready && k < 64) begin @(negedge clk); k++; end
    n_cmp++;
    if (o_req_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL req_accept ch%0d: ready=%0b required 1 within 64 cycles", ch, o_req_ready);
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k;
    k = 0;
    while (wr_dat.size() < n && k < budget) begin @(posedge clk); #1; k++; end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (o_wb_cyc !== 1'b0)  begin n_mis++; $display("FAIL rst_cyc: got %0b required 0", o_wb_cyc); end
    n_cmp++; if (o_wb_stb !== 1'b0)  begin n_mis++; $display("FAIL rst_stb: got %0b required 0", o_wb_stb); end
    n_cmp++; if (o_wb_we !== 1'b1)   begin n_mis++; $display("FAIL rst_we: got %0b required 1", o_wb_we); end
    n_cmp++; if (o_wb_adr !== 16'h0) begin n_mis++; $display("FAIL rst_adr: got %h required 0000", o_wb_adr); end
    n_cmp++; if (o_wb_data !== 16'h0) begin n_mis++; $display("FAIL rst_data: got %h required 0000", o_wb_data); end
    n_cmp++; if (o_active !== 4'h0)  begin n_mis++; $display("FAIL rst_active: got %b required 0000", o_active); end
    n_cmp++; if (o_done !== 4'h0)    begin n_mis++; $display("FAIL rst_done: got %b required 0000", o_done); end
    n_cmp++; if (o_err !== 4'h0)     begin n_mis++; $display("FAIL rst_err: got %b required 0000", o_err); end
    n_cmp++; if (o_req_ready !== 1'b1) begin n_mis++; $display("FAIL rst_ready: got %0b required 1", o_req_ready); end
    rst = 1'b0;
    cyc_cycles = 0;
    repeat (3 * TDIV) @(posedge clk);
    #1;
    n_cmp++; if (cyc_cycles !== 0) begin n_mis++; $display("FAIL rst_quiet_bus: got %0d busy cycles required 0", cyc_cycles); end
  endtask

  task automatic test_up_ramp();
    int base, d0;
    logic [15:0] exp_d[3];
    exp_d = '{16'd508, 16'd516, 16'd520};
    base = wr_dat.size();
    d0 = done_cnt[1];
    do_req(3'd1, 16'd520, 16'd8);
    n_cmp++; if (o_active[1] !== 1'b1) begin n_mis++; $display("FAIL up_active_set: got %0b required 1", o_active[1]); end
    wait_writes(base + 3, 200);
    n_cmp++;
    if (wr_dat.size() !== base + 3) begin
      n_mis++; $display("FAIL up_write_count: got %0d required %0d", wr_dat.size() - base, 3);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (wr_adr[base+i] !== 16'h0006) begin n_mis++; $display("FAIL up_adr[%0d]: got %h required 0006", i, wr_adr[base+i]); end
        n_cmp++; if (wr_dat[base+i] !== exp_d[i]) begin n_mis++; $display("FAIL up_data[%0d]: got %0d required %0d", i, wr_dat[base+i], exp_d[i]); end
      end
    end
    repeat (4 * TDIV) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt[1] - d0 !== 1) begin n_mis++; $display("FAIL up_done_pulses: got %0d required 1", done_cnt[1] - d0); end
    n_cmp++; if (o_active[1] !== 1'b0) begin n_mis++; $display("FAIL up_active_clr: got %0b required 0", o_active[1]); end
    n_cmp++; if (wr_dat.size() !== base + 3) begin n_mis++; $display("FAIL up_no_extra: got %0d writes required 3", wr_dat.size() - base); end
  endtask

  task automatic test_down_jump();
    int base, d0;
    logic [15:0] exp_d[4];
    exp_d = '{16'd496, 16'd492, 16'd490, 16'd1000};
    base = wr_dat.size();
    d0 = done_cnt[0];
    do_req(3'd0, 16'd490, 16'd4);
    wait_writes(base + 3, 200);
    repeat (2) @(posedge clk);
    #1;
    do_req(3'd0, 16'd1000, 16'd0);
    wait_writes(base + 4, 200);
    repeat (4 * TDIV) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_dat.size() !== base + 4) begin
      n_mis++; $display("FAIL dn_write_count: got %0d required 4", wr_dat.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (wr_adr[base+i] !== 16'h0002) begin n_mis++; $display("FAIL dn_adr[%0d]: got %h required 0002", i, wr_adr[base+i]); end
        n_cmp++; if (wr_dat[base+i] !== exp_d[i]) begin n_mis++; $display("FAIL dn_data[%0d]: got %0d required %0d", i, wr_dat[base+i], exp_d[i]); end
      end
    end
    n_cmp++; if (done_cnt[0] - d0 !== 2) begin n_mis++; $display("FAIL dn_done_pulses: got %0d required 2", done_cnt[0] - d0); end
  endtask

  task automatic test_round_robin();
    int base;
    int d0, d2, d3;
    logic [15:0] exp_a[6];
    logic [15:0] exp_d[6];
    exp_a = '{16'h0002, 16'h000A, 16'h000E, 16'h0002, 16'h000A, 16'h000E};
    exp_d = '{16'd550, 16'd550, 16'd550, 16'd600, 16'd600, 16'd600};
    pulse_reset();
    base = wr_dat.size();
    d0 = done_cnt[0]; d2 = done_cnt[2]; d3 = done_cnt[3];
    do_req(3'd0, 16'd600, 16'd50);
    do_req(3'd2, 16'd600, 16'd50);
    do_req(3'd3, 16'd600, 16'd50);
    wait_writes(base + 6, 300);
    repeat (4 * TDIV) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_dat.size() !== base + 6) begin
      n_mis++; $display("FAIL rr_write_count: got %0d required 6", wr_dat.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++; if (wr_adr[base+i] !== exp_a[i]) begin n_mis++; $display("FAIL rr_adr[%0d]: got %h required %h", i, wr_adr[base+i], exp_a[i]); end
        n_cmp++; if (wr_dat[base+i] !== exp_d[i]) begin n_mis++; $display("FAIL rr_data[%0d]: got %0d required %0d", i, wr_dat[base+i], exp_d[i]); end
      end
    end
    n_cmp++;
    if ((done_cnt[0] - d0 !== 1) || (done_cnt[2] - d2 !== 1) || (done_cnt[3] - d3 !== 1)) begin
      n_mis++; $display("FAIL rr_done_pulses: got %0d/%0d/%0d required 1/1/1", done_cnt[0]-d0, done_cnt[2]-d2, done_cnt[3]-d3);
    end
  endtask

  task automatic test_timeout();
    int base, d2;
    ack_en = 1'b0;
    base = wr_dat.size();
    cyc_cycles = 0;
    do_req(3'd2, 16'd700, 16'd10);
    repeat (40) @(posedge clk);
    #1;
    n_cmp++; if (cyc_cycles !== ATO)  begin n_mis++; $display("FAIL to_cyc_len: got %0d cycles required %0d", cyc_cycles, ATO); end
    n_cmp++; if (o_wb_cyc !== 1'b0)   begin n_mis++; $display("FAIL to_cyc_drop: got %0b required 0", o_wb_cyc); end
    n_cmp++; if (o_err[2] !== 1'b1)   begin n_mis++; $display("FAIL to_err_set: got %0b required 1", o_err[2]); end
    n_cmp++; if (o_active[2] !== 1'b0) begin n_mis++; $display("FAIL to_active_clr: got %0b required 0", o_active[2]); end
    ack_en = 1'b1;
    d2 = done_cnt[2];
    // cur must still be 600 after the aborted write, so this is an immediate completion.
    do_req(3'd2, 16'd600, 16'd0);
    n_cmp++; if (o_err[2] !== 1'b0)   begin n_mis++; $display("FAIL to_err_clr: got %0b required 0", o_err[2]); end
    n_cmp++; if (o_done[2] !== 1'b1)  begin n_mis++; $display("FAIL to_done_same: got %0b required 1", o_done[2]); end
    repeat (3 * TDIV) @(posedge clk);
    #1;
    n_cmp++; if (wr_dat.size() !== base) begin n_mis++; $display("FAIL to_no_write: got %0d writes required 0", wr_dat.size() - base); end
    n_cmp++; if (done_cnt[2] - d2 !== 1) begin n_mis++; $display("FAIL to_done_count: got %0d required 1", done_cnt[2] - d2); end
  endtask

  task automatic test_retarget_reset();
    int base, k;
    logic [15:0] exp_d[4];
    exp_d = '{16'd510, 16'd520, 16'd530, 16'd520};
    base = wr_dat.size();
    do_req(3'd1, 16'd510, 16'd0);
    wait_writes(base + 1, 100);
    do_req(3'd1, 16'd600, 16'd10);
    wait_writes(base + 3, 200);
    do_req(3'd1, 16'd500, 16'd10);
    wait_writes(base + 4, 200);
    ack_en = 1'b0;
    n_cmp++;
    if (wr_dat.size() !== base + 4) begin
      n_mis++; $display("FAIL rt_write_count: got %0d required 4", wr_dat.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (wr_adr[base+i] !== 16'h0006) begin n_mis++; $display("FAIL rt_adr[%0d]: got %h required 0006", i, wr_adr[base+i]); end
        n_cmp++; if (wr_dat[base+i] !== exp_d[i]) begin n_mis++; $display("FAIL rt_data[%0d]: got %0d required %0d", i, wr_dat[base+i], exp_d[i]); end
      end
    end
    k = 0;
    while (!o_wb_cyc && k < 40) begin @(posedge clk); #1; k++; end
    n_cmp++; if (o_wb_cyc !== 1'b1) begin n_mis++; $display("FAIL rt_write_start: got cyc=%0b required 1", o_wb_cyc); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (o_wb_cyc !== 1'b0) begin n_mis++; $display("FAIL rt_rst_cyc: got %0b required 0", o_wb_cyc); end
    n_cmp++; if (o_wb_stb !== 1'b0) begin n_mis++; $display("FAIL rt_rst_stb: got %0b required 0", o_wb_stb); end
    n_cmp++; if (o_active !== 4'h0) begin n_mis++; $display("FAIL rt_rst_active: got %b required 0000", o_active); end
    @(posedge clk); #1;
    rst = 1'b0;
    ack_en = 1'b1;
    // cur is back at 500 (was 520), so target 500 completes without a write.
    do_req(3'd1, 16'd500, 16'd0);
    n_cmp++; if (o_done[1] !== 1'b1)   begin n_mis++; $display("FAIL rt_cur_reset_done: got %0b required 1", o_done[1]); end
    n_cmp++; if (o_active[1] !== 1'b0) begin n_mis++; $display("FAIL rt_cur_reset_active: got %0b required 0", o_active[1]); end
    repeat (3 * TDIV) @(posedge clk);
    #1;
    n_cmp++; if (wr_dat.size() !== base + 4) begin n_mis++; $display("FAIL rt_no_write: got %0d writes required 4", wr_dat.size() - base); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_up_ramp();
    test_down_jump();
    test_round_robin();
    test_timeout();
    test_retarget_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
